// File: rtl/dram_pkg.sv
// Shared definitions for the DRAM host controller and the 16x8 memory model:
// widths, memory state encodings, controller state encodings.
package dram_pkg;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;

    // Memory curr_state encodings, shared with the memory model
    localparam logic [1:0] MS_IDLE    = 2'b00;
    localparam logic [1:0] MS_READ    = 2'b01;
    localparam logic [1:0] MS_WRITE   = 2'b10;
    localparam logic [1:0] MS_REFRESH = 2'b11;

    typedef logic [1:0] ctrl_state_t;

    localparam ctrl_state_t C_IDLE  = 2'd0;
    localparam ctrl_state_t C_ISSUE = 2'd1;
    localparam ctrl_state_t C_WAIT  = 2'd2;

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/dram_ctrl_if.sv
// Host command/response bundle for dram_ctrl: valid/ready command channel
// plus a one-cycle response pulse.
interface dram_ctrl_if;
    import dram_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_we;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic              rsp_we;
    logic [DATA_W-1:0] rsp_data;

    modport master (
        output cmd_valid, cmd_we, cmd_addr, cmd_wdata,
        input  cmd_ready, rsp_valid, rsp_we, rsp_data
    );

    modport slave (
        input  cmd_valid, cmd_we, cmd_addr, cmd_wdata,
        output cmd_ready, rsp_valid, rsp_we, rsp_data
    );

endinterface

// File: rtl/dram_refresh_timer.sv
// Tracks cycles since the memory last sat in REFRESH and flags when requests
// must be withheld; also counts every observed REFRESH cycle.
module dram_refresh_timer
    import dram_pkg::*;
#(
    parameter int REF_INTERVAL = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] mem_state,
    output logic       refresh_due,
    output logic [7:0] refresh_count
);

    logic [3:0] ref_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            ref_cnt       <= '0;
            refresh_count <= '0;
        end else if (mem_state == MS_REFRESH) begin
            ref_cnt       <= '0;
            refresh_count <= refresh_count + 8'd1;
        end else begin
            ref_cnt       <= sat_inc4(ref_cnt);
        end
    end

    assign refresh_due = (ref_cnt >= 4'(REF_INTERVAL));

endmodule

// File: rtl/dram_ctrl.sv
// Host-side initiator for the 16x8 DRAM model: accepts one command at a time,
// issues it in the memory's IDLE slot, and returns a one-cycle response.
module dram_ctrl
    import dram_pkg::*;
#(
    parameter int REF_INTERVAL = 8
) (
    input  logic              clk,
    input  logic              reset,
    dram_ctrl_if.slave        host,
    output logic              mem_read_r,
    output logic              mem_write_r,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    input  logic [DATA_W-1:0] mem_read_data,
    input  logic [1:0]        mem_state,
    output logic [7:0]        refresh_count,
    output logic              proto_err
);

    ctrl_state_t state;
    logic        we_p0;
    logic        refresh_due;
    logic        accept;
    logic        issue_ok;
    logic [1:0]  exp_state;

    dram_refresh_timer #(
        .REF_INTERVAL (REF_INTERVAL)
    ) u_refresh_timer (
        .clk           (clk),
        .reset         (reset),
        .mem_state     (mem_state),
        .refresh_due   (refresh_due),
        .refresh_count (refresh_count)
    );

    assign host.cmd_ready = (state == C_IDLE) || (state == C_WAIT);
    assign accept         = host.cmd_valid && host.cmd_ready;

    // Requests are combinational on state so a reset drops them immediately
    assign issue_ok    = (state == C_ISSUE) && (mem_state == MS_IDLE) && !refresh_due;
    assign mem_read_r  = issue_ok && !we_p0;
    assign mem_write_r = issue_ok && we_p0;
    assign exp_state   = we_p0 ? MS_WRITE : MS_READ;

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= C_IDLE;
            we_p0          <= 1'b0;
            mem_addr       <= '0;
            mem_data       <= '0;
            host.rsp_valid <= 1'b0;
            host.rsp_we    <= 1'b0;
            host.rsp_data  <= '0;
            proto_err      <= 1'b0;
        end else begin
            host.rsp_valid <= 1'b0;
            if (accept) begin
                we_p0    <= host.cmd_we;
                mem_addr <= host.cmd_addr;
                mem_data <= host.cmd_wdata;
            end
            case (state)
                C_IDLE: begin
                    if (accept) state <= C_ISSUE;
                end
                C_ISSUE: begin
                    if (issue_ok) state <= C_WAIT;
                end
                C_WAIT: begin
                    // Memory is mid-operation here; the response goes out regardless
                    host.rsp_valid <= 1'b1;
                    host.rsp_we    <= we_p0;
                    if (!we_p0) host.rsp_data <= mem_read_data;
                    if (mem_state != exp_state) proto_err <= 1'b1;
                    state <= accept ? C_ISSUE : C_IDLE;
                end
                default: state <= C_IDLE;
            endcase
        end
    end

endmodule
